// File: rtl/keypad_scanner.sv
// keypad_scanner: scans, synchronises and debounces a 4-col x 5-row key matrix.
// Ports: clk, rst_n, col_n[3:0] out, row_n[4:0] in, b_0..b_f/b_load/b_storeinc/b_dec/b_step
//   one-cycle pulses, any_held level. Optional auto-repeat: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 32,
    parameter int REPEAT_RATE    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] col_n,
    input  logic [4:0] row_n,
    output logic       b_0,
    output logic       b_1,
    output logic       b_2,
    output logic       b_3,
    output logic       b_4,
    output logic       b_5,
    output logic       b_6,
    output logic       b_7,
    output logic       b_8,
    output logic       b_9,
    output logic       b_a,
    output logic       b_b,
    output logic       b_c,
    output logic       b_d,
    output logic       b_e,
    output logic       b_f,
    output logic       b_load,
    output logic       b_storeinc,
    output logic       b_dec,
    output logic       b_step,
    output logic       any_held
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_SCANS);

    logic [4:0]    sync1_q, sync2_q;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    col_q, col_d;
    logic [19:0]   acc_q, acc_d;
    logic [19:0]   prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [19:0]   stable_q, stable_d;
    logic [19:0]   pulse_q, pulse_d;
    logic [4:0]    hit;
    logic          scan_end, full, multi;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_DELAY + REPEAT_RATE);
    localparam logic [19:0]   KEY_STOREINC = 20'h20000;
    localparam logic [19:0]   KEY_DEC      = 20'h40000;
    logic [RW-1:0] rep_q, rep_d;
`else
    logic unused_rep;
    assign unused_rep = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

    assign hit      = ~sync2_q;
    assign scan_end = (div_q == DIV_LAST);
    assign full     = scan_end && (col_q == 2'd3);
    assign col_n    = ~(4'b0001 << col_q);
    assign any_held = |stable_q;

    assign {b_step, b_dec, b_storeinc, b_load,
            b_f, b_e, b_d, b_c, b_b, b_a, b_9, b_8,
            b_7, b_6, b_5, b_4, b_3, b_2, b_1, b_0} = pulse_q;

    always_comb begin
        div_d    = scan_end ? '0 : div_q + DW'(1);
        col_d    = scan_end ? col_q + 2'd1 : col_q;
        acc_d    = acc_q;
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        pulse_d  = '0;
`ifdef KEYPAD_REPEAT_EN
        rep_d    = rep_q;
`endif
        if (scan_end) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (2'(c) == col_q) acc_d[r*4+c] = hit[r];
                end
            end
        end
        // acc_d now holds the complete snapshot on the last cycle of column 3
        multi = |(acc_d & (acc_d - 20'd1));
        if (full) begin
            if (multi) begin
                cnt_d = '0;
            end else begin
                if (acc_d == prev_q)
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                else
                    cnt_d = CW'(1);
                prev_d = acc_d;
                if (cnt_d >= CNT_MAX) stable_d = acc_d;
            end
            pulse_d = stable_d & ~stable_q;
`ifdef KEYPAD_REPEAT_EN
            if (stable_d != stable_q ||
                !(stable_q == KEY_STOREINC || stable_q == KEY_DEC)) begin
                rep_d = '0;
            end else begin
                rep_d = rep_q + RW'(1);
                if (rep_d == REP_FIRST) begin
                    pulse_d = stable_q;
                end else if (rep_d == REP_NEXT) begin
                    pulse_d = stable_q;
                    rep_d   = REP_FIRST;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 5'h1f;
            sync2_q  <= 5'h1f;
            div_q    <= '0;
            col_q    <= '0;
            acc_q    <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            pulse_q  <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep_q    <= '0;
`endif
        end else begin
            sync1_q  <= row_n;
            sync2_q  <= sync1_q;
            div_q    <= div_d;
            col_q    <= col_d;
            acc_q    <= acc_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q    <= rep_d;
`endif
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a matrix model.
// Small parameters: 4-cycle columns, 16-cycle scans, 3-scan debounce.
module tb_keypad_scanner;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] col_n;
    logic [4:0] row_n;
    logic [19:0] pv;
    logic       any_held;
    logic [19:0] press;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int cnt [20];
    int total = 0;
    int dec_t [64];
    int dec_n = 0;
    int base [20];
    int base_tot;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV(4), .DEBOUNCE_SCANS(3), .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n),
        .b_0(pv[0]), .b_1(pv[1]), .b_2(pv[2]), .b_3(pv[3]),
        .b_4(pv[4]), .b_5(pv[5]), .b_6(pv[6]), .b_7(pv[7]),
        .b_8(pv[8]), .b_9(pv[9]), .b_a(pv[10]), .b_b(pv[11]),
        .b_c(pv[12]), .b_d(pv[13]), .b_e(pv[14]), .b_f(pv[15]),
        .b_load(pv[16]), .b_storeinc(pv[17]), .b_dec(pv[18]),
        .b_step(pv[19]), .any_held(any_held)
    );

    // key(r,c) pulls row r low while column c is driven low
    always_comb begin
        row_n = 5'h1f;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 4; c++)
                if (!col_n[c] && press[r*4+c]) row_n[r] = 1'b0;
    end

    initial for (int k = 0; k < 20; k++) cnt[k] = 0;

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 20; k++) begin
            if (pv[k]) begin
                cnt[k]++;
                total++;
            end
        end
        if (pv[18] && dec_n < 64) begin
            dec_t[dec_n] = cyc;
            dec_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic mark();
        for (int k = 0; k < 20; k++) base[k] = cnt[k];
        base_tot = total;
    endtask

    function automatic int seen(input int k);
        return cnt[k] - base[k];
    endfunction

    task automatic wait_col(input logic [3:0] v, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (col_n == v) found = 1'b1;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        int b;
        rst_n = 1'b0;
        press = '0;
        cycles(3);
        #1;
        check("rst_col", {28'd0, col_n}, 32'hE);
        check("rst_held", {31'd0, any_held}, 32'd0);
        check("rst_pulse", {12'd0, pv}, 32'd0);

        // 1: clean hold of key(1,1) -> b_5
        press = 20'h1 << 5;
        @(posedge clk);
        rst_n = 1'b1;
        mark();
        cycles(68);
        check("t1_b5", seen(5), 1);
        check("t1_tot", total - base_tot, 1);
        cycles(500);
        check("t1_tot500", total - base_tot, 1);
        check("t1_held", {31'd0, any_held}, 32'd1);

        // 2: bouncing key(2,3)
        press = '0;
        cycles(100);
        check("t2_rel_held", {31'd0, any_held}, 32'd0);
        mark();
        for (int i = 0; i < 20; i++) begin
            press = press ^ (20'h1 << 11);
            cycles(6);
        end
        check("t2_bounce", total - base_tot, 0);
        press = 20'h1 << 11;
        cycles(100);
        check("t2_bb", seen(11), 1);
        check("t2_tot", total - base_tot, 1);

        // 3: two keys at once rejected, release one -> b_3
        press = '0;
        cycles(100);
        mark();
        press = (20'h1 << 3) | (20'h1 << 4);
        cycles(150);
        check("t3_ghost", total - base_tot, 0);
        check("t3_held", {31'd0, any_held}, 32'd0);
        press = 20'h1 << 3;
        cycles(100);
        check("t3_b3", seen(3), 1);
        check("t3_tot", total - base_tot, 1);

        // 4: column walk, then load twice
        press = '0;
        cycles(100);
        wait_col(4'hE, "t4_sync");
        repeat (4) @(negedge clk);
        check("t4_c1", {28'd0, col_n}, 32'hD);
        repeat (4) @(negedge clk);
        check("t4_c2", {28'd0, col_n}, 32'hB);
        repeat (4) @(negedge clk);
        check("t4_c3", {28'd0, col_n}, 32'h7);
        repeat (4) @(negedge clk);
        check("t4_c0", {28'd0, col_n}, 32'hE);
        @(posedge clk);
        mark();
        press = 20'h1 << 16;
        cycles(100);
        press = '0;
        cycles(100);
        press = 20'h1 << 16;
        cycles(100);
        check("t4_load", seen(16), 2);
        check("t4_tot", total - base_tot, 2);

        // 5: reset mid-column while key(3,2) held
        press = '0;
        cycles(100);
        mark();
        press = 20'h1 << 14;
        cycles(100);
        check("t5_pre", seen(14), 1);
        wait_col(4'hB, "t5_sync");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_col", {28'd0, col_n}, 32'hE);
        check("t5_held", {31'd0, any_held}, 32'd0);
        check("t5_pulse", {12'd0, pv}, 32'd0);
        cycles(3);
        rst_n = 1'b1;
        mark();
        cycles(100);
        check("t5_be", seen(14), 1);
        check("t5_tot", total - base_tot, 1);

        // 6: dec key auto-repeat
        press = '0;
        cycles(100);
        mark();
        b = dec_n;
        press = 20'h1 << 18;
        cycles(200);
`ifdef KEYPAD_REPEAT_EN
        check("t6_n", {31'd0, (dec_n - b) >= 3}, 32'd1);
        check("t6_first", dec_t[b+1] - dec_t[b], 64);
        check("t6_rate", dec_t[b+2] - dec_t[b+1], 32);
        press = '0;
        cycles(100);
        mark();
        cycles(100);
        check("t6_stop", total - base_tot, 0);
`else
        check("t6_single", seen(18), 1);
        check("t6_tot", total - base_tot, 1);
        press = '0;
        cycles(100);
        check("t6_rel", total - base_tot, 1);
`endif
        check("t6_held", {31'd0, any_held}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
